// File: rtl/reg_datapath.sv
// ---------------------------------------------------------------------------
// reg_datapath -- 8-bit CPU register file and address/data path.
//
// Holds the eight-bit registers B, C, D, E, H, L, A, the flag nibble F[7:4],
// the 16-bit SP and PC, the instruction register IR and the W/Z temporaries.
// A control sequencer drives one set of per-cycle strobes. Bus address,
// write data and ALU operand are produced combinationally from the current
// register state. Every write lands at the rising edge, and nothing is
// forwarded within the same cycle.
//
// Configuration macro:
//   POST_BOOT_RESET_EN  when defined, reset loads the post-boot-ROM register
//                       image (A=01 F=B0 BC=0013 DE=00D8 HL=014D PC=0100).
//                       When it is undefined, everything clears to zero
//                       except SP, which resets to FFFE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   addr_sel[1:0]            address source: PC / GP16 / WZ / FF00+C
//   inc_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8, capture_alu_res,
//   r8_to_alu_op1, update_flags, r8_to_mem, z_to_mem, halt   strobes
//   r8_dst[2:0], r8_src[2:0] register index (B C D E H L (HL) A)
//   gp16_sel[2:0]            pointer pair: BC DE HL HL+ HL- SP (6,7 = HL)
//   mem_rdata[7:0]           bus read data, valid in the address cycle
//   alu_res[7:0], alu_flags[3:0]   ALU result and Z,N,H,C flags
//   mem_addr[15:0], mem_wdata[7:0], mem_we   bus outputs
//   ir[7:0], alu_op1[7:0], alu_acc[7:0], flags[3:0], pc[15:0]
// ---------------------------------------------------------------------------
module reg_datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr_sel,
    input  logic        inc_pc,
    input  logic        mem_to_z,
    input  logic        mem_to_w,
    input  logic        mem_to_ir,
    input  logic        mem_to_r8,
    input  logic        capture_alu_res,
    input  logic        r8_to_alu_op1,
    input  logic        update_flags,
    input  logic        r8_to_mem,
    input  logic        z_to_mem,
    input  logic        halt,
    input  logic [2:0]  r8_dst,
    input  logic [2:0]  r8_src,
    input  logic [2:0]  gp16_sel,
    input  logic [7:0]  mem_rdata,
    input  logic [7:0]  alu_res,
    input  logic [3:0]  alu_flags,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic [7:0]  ir,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_acc,
    output logic [3:0]  flags,
    output logic [15:0] pc
);

    localparam logic [2:0] IDX_H  = 3'd4;
    localparam logic [2:0] IDX_L  = 3'd5;
    localparam logic [2:0] IDX_HL = 3'd6;
    localparam logic [2:0] IDX_A  = 3'd7;

    // Reset image, one byte per register index {A, (HL), L, H, E, D, C, B}.
    // Slot 6 is memory-indirect and has no storage behind it.
`ifdef POST_BOOT_RESET_EN
    localparam logic [63:0] R8_RST = 64'h01_00_4D_01_D8_00_13_00;
    localparam logic [3:0]  F_RST  = 4'hB;
    localparam logic [15:0] PC_RST = 16'h0100;
`else
    localparam logic [63:0] R8_RST = 64'h00_00_00_00_00_00_00_00;
    localparam logic [3:0]  F_RST  = 4'h0;
    localparam logic [15:0] PC_RST = 16'h0000;
`endif
    localparam logic [15:0] SP_RST = 16'hFFFE;

    logic [7:0]  r8_file [0:7];
    logic [3:0]  flag_reg;
    logic [15:0] sp_reg;
    logic [15:0] pc_reg;
    logic [7:0]  ir_reg;
    logic [7:0]  z_reg;
    logic [7:0]  w_reg;

    logic        r8_we;
    logic [7:0]  r8_wdata;
    logic        hl_access;
    logic        hl_step;
    logic        hl_upd;
    logic [15:0] hl_cur;
    logic [15:0] hl_next;
    logic [15:0] gp16_addr;
    logic [2:0]  wdata_src;

    // ------------------------------------------------------------------
    // r8 write port. The ALU result takes priority over bus data, and
    // writes to the (HL) slot are dropped because it has no storage.
    // ------------------------------------------------------------------
    assign r8_we    = (capture_alu_res | mem_to_r8) && (r8_dst != IDX_HL);
    assign r8_wdata = capture_alu_res ? alu_res : mem_rdata;

    // HL post-increment/decrement happens only on a real bus access through
    // the HL+ or HL- pointer. An explicit r8 write to H or L in the same
    // cycle cancels the whole 16-bit step, so neither half is updated.
    assign hl_cur    = {r8_file[IDX_H], r8_file[IDX_L]};
    assign hl_access = mem_to_z | mem_to_r8 | r8_to_mem | z_to_mem;
    assign hl_step   = (addr_sel == 2'd1) && hl_access &&
                       ((gp16_sel == 3'd3) || (gp16_sel == 3'd4));
    assign hl_upd    = hl_step && !(r8_we && ((r8_dst == IDX_H) || (r8_dst == IDX_L)));
    assign hl_next   = (gp16_sel == 3'd3) ? hl_cur + 16'd1 : hl_cur - 16'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_r8
            if (gi == 6) begin : g_none
                assign r8_file[gi] = 8'h00;
            end else begin : g_reg
                localparam logic [2:0] IDX    = 3'(gi);
                localparam bit         IS_HL  = (gi == 4) || (gi == 5);
                localparam int         HL_LSB = (gi == 4) ? 8 : 0;
                logic [7:0] q_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= R8_RST[gi*8 +: 8];
                    end else if (r8_we && (r8_dst == IDX)) begin
                        q_reg <= r8_wdata;
                    end else if (IS_HL && hl_upd) begin
                        q_reg <= hl_next[HL_LSB +: 8];
                    end
                end

                assign r8_file[gi] = q_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Special registers. Halt freezes instruction fetch (PC and IR) only.
    // SP has no write path here; it only takes its reset value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_reg <= F_RST;
            sp_reg   <= SP_RST;
            pc_reg   <= PC_RST;
            ir_reg   <= 8'h00;
            z_reg    <= 8'h00;
            w_reg    <= 8'h00;
        end else begin
            if (update_flags)
                flag_reg <= alu_flags;
            if (inc_pc && !halt)
                pc_reg <= pc_reg + 16'd1;
            if (mem_to_ir && !halt)
                ir_reg <= mem_rdata;
            if (mem_to_z)
                z_reg <= mem_rdata;
            if (mem_to_w)
                w_reg <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        gp16_addr = hl_cur;
        case (gp16_sel)
            3'd0:    gp16_addr = {r8_file[0], r8_file[1]};
            3'd1:    gp16_addr = {r8_file[2], r8_file[3]};
            3'd5:    gp16_addr = sp_reg;
            default: gp16_addr = hl_cur;
        endcase
    end

    always_comb begin
        mem_addr = pc_reg;
        case (addr_sel)
            2'd0:    mem_addr = pc_reg;
            2'd1:    mem_addr = gp16_addr;
            2'd2:    mem_addr = {w_reg, z_reg};
            default: mem_addr = {8'hFF, r8_file[1]};
        endcase
    end

    // For a bus write the (HL) slot sources A.
    assign wdata_src = (r8_src == IDX_HL) ? IDX_A : r8_src;
    assign mem_wdata = z_to_mem ? z_reg : r8_file[wdata_src];
    assign mem_we    = (r8_to_mem | z_to_mem) & ~rst;

    // For the ALU the (HL) slot means "operand already fetched into Z".
    assign alu_op1 = (r8_to_alu_op1 && (r8_src != IDX_HL)) ? r8_file[r8_src] : z_reg;
    assign alu_acc = r8_file[IDX_A];
    assign flags   = flag_reg;
    assign ir      = ir_reg;
    assign pc      = pc_reg;

endmodule

// File: tb/tb_reg_datapath.sv
// ---------------------------------------------------------------------------
// tb_reg_datapath -- directed self-checking bench for reg_datapath.
// Expected values are pushed into a scoreboard queue as stimulus is applied
// and popped when the corresponding DUT output is sampled.
// Set POST_BOOT_RESET_EN here too when the DUT is built with it.
// ---------------------------------------------------------------------------
module tb_reg_datapath;

    logic        clk;
    logic        rst;
    logic [1:0]  addr_sel;
    logic        inc_pc, mem_to_z, mem_to_w, mem_to_ir, mem_to_r8;
    logic        capture_alu_res, r8_to_alu_op1, update_flags;
    logic        r8_to_mem, z_to_mem, halt;
    logic [2:0]  r8_dst, r8_src, gp16_sel;
    logic [7:0]  mem_rdata, alu_res;
    logic [3:0]  alu_flags;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  ir, alu_op1, alu_acc;
    logic [3:0]  flags;
    logic [15:0] pc;

    reg_datapath dut (
        .clk(clk), .rst(rst), .addr_sel(addr_sel),
        .inc_pc(inc_pc), .mem_to_z(mem_to_z), .mem_to_w(mem_to_w),
        .mem_to_ir(mem_to_ir), .mem_to_r8(mem_to_r8),
        .capture_alu_res(capture_alu_res), .r8_to_alu_op1(r8_to_alu_op1),
        .update_flags(update_flags), .r8_to_mem(r8_to_mem),
        .z_to_mem(z_to_mem), .halt(halt),
        .r8_dst(r8_dst), .r8_src(r8_src), .gp16_sel(gp16_sel),
        .mem_rdata(mem_rdata), .alu_res(alu_res), .alu_flags(alu_flags),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .ir(ir), .alu_op1(alu_op1), .alu_acc(alu_acc),
        .flags(flags), .pc(pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state kept by the bench
    logic [7:0]  m_r8 [0:7];
    logic [15:0] m_pc;
    logic [3:0]  m_f_rst;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        addr_sel = 2'd0; inc_pc = 0; mem_to_z = 0; mem_to_w = 0;
        mem_to_ir = 0; mem_to_r8 = 0; capture_alu_res = 0;
        r8_to_alu_op1 = 0; update_flags = 0; r8_to_mem = 0;
        z_to_mem = 0; halt = 0; r8_dst = 3'd0; r8_src = 3'd0;
        gp16_sel = 3'd2; mem_rdata = 8'h00; alu_res = 8'h00;
        alu_flags = 4'h0;
    endtask

    task automatic put(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic get(input logic [15:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            $display("check %-14s observed=%h expected=%h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic load_r8(input logic [2:0] idx, input logic [7:0] v);
        idle();
        mem_to_r8 = 1; r8_dst = idx; mem_rdata = v;
        tick();
        idle();
        if (idx != 3'd6) m_r8[idx] = v;
    endtask

    task automatic set_a(input logic [7:0] v);
        idle();
        capture_alu_res = 1; r8_dst = 3'd7; alu_res = v;
        tick();
        idle();
        m_r8[7] = v;
    endtask

    task automatic peek_r8(input string tag, input logic [2:0] idx);
        idle();
        r8_to_alu_op1 = 1; r8_src = idx;
        #1;
        put(tag, {8'h00, m_r8[idx]});
        get({8'h00, alu_op1});
        idle();
    endtask

    task automatic peek_hl(input string tag);
        idle();
        addr_sel = 2'd1; gp16_sel = 3'd2;
        #1;
        put(tag, {m_r8[4], m_r8[5]});
        get(mem_addr);
        idle();
    endtask

    task automatic peek_z(input string tag, input logic [7:0] v);
        idle();
        #1;
        put(tag, {8'h00, v});
        get({8'h00, alu_op1});
    endtask

    initial begin
`ifdef POST_BOOT_RESET_EN
        m_r8[0] = 8'h00; m_r8[1] = 8'h13; m_r8[2] = 8'h00; m_r8[3] = 8'hD8;
        m_r8[4] = 8'h01; m_r8[5] = 8'h4D; m_r8[6] = 8'h00; m_r8[7] = 8'h01;
        m_pc = 16'h0100; m_f_rst = 4'hB;
`else
        for (int i = 0; i < 8; i++) m_r8[i] = 8'h00;
        m_pc = 16'h0000; m_f_rst = 4'h0;
`endif

        // Reset overrides active controls; no bus write while in reset.
        idle();
        rst = 1; inc_pc = 1; r8_to_mem = 1; z_to_mem = 1;
        mem_to_ir = 1; mem_rdata = 8'h3E;
        #1;
        put("we_in_rst", 16'h0000); get({15'd0, mem_we});
        tick();
        tick();
        rst = 0;
        idle();
        #1;
        put("rst_pc", m_pc);              get(pc);
        put("rst_ir", 16'h0000);          get({8'h00, ir});
        put("rst_flags", {12'd0, m_f_rst}); get({12'd0, flags});
        put("rst_a", {8'h00, m_r8[7]});   get({8'h00, alu_acc});
        peek_z("rst_z", 8'h00);
        addr_sel = 2'd1; gp16_sel = 3'd5; #1;
        put("rst_sp", 16'hFFFE);          get(mem_addr);
        addr_sel = 2'd2; #1;
        put("rst_wz", 16'h0000);          get(mem_addr);
        peek_r8("rst_c", 3'd1);
        peek_hl("rst_hl");

        // Three increments.
        idle(); inc_pc = 1;
        repeat (3) tick();
        idle(); m_pc = m_pc + 16'd3;
        put("pc_inc3", m_pc); get(pc);

        // Walk PC up to FFFF, then wrap.
        inc_pc = 1;
        repeat (32'h0000FFFF - 32'(m_pc)) @(posedge clk);
        #1; idle();
        put("pc_ffff", 16'hFFFF); get(pc);
        inc_pc = 1; tick(); idle();
        put("pc_wrap", 16'h0000); get(pc);

        // IR load, then halt freezes PC/IR but not Z.
        mem_to_ir = 1; mem_rdata = 8'h76; tick(); idle();
        put("ir_load", 16'h0076); get({8'h00, ir});
        halt = 1; inc_pc = 1; mem_to_ir = 1; mem_to_z = 1; mem_rdata = 8'h3E;
        tick(); idle();
        put("halt_pc", 16'h0000); get(pc);
        put("halt_ir", 16'h0076); get({8'h00, ir});
        peek_z("halt_z", 8'h3E);

        // HL+ write of A, with carry across the byte boundary.
        load_r8(3'd4, 8'hC0); load_r8(3'd5, 8'hFF); set_a(8'h5A);
        addr_sel = 2'd1; gp16_sel = 3'd3; r8_to_mem = 1; r8_src = 3'd7;
        #1;
        put("hlp_addr", 16'hC0FF);  get(mem_addr);
        put("hlp_we", 16'h0001);    get({15'd0, mem_we});
        put("hlp_wdata", 16'h005A); get({8'h00, mem_wdata});
        tick(); idle();
        m_r8[4] = 8'hC1; m_r8[5] = 8'h00;
        peek_hl("hlp_next");

        // HL- from 0000 wraps to FFFF.
        load_r8(3'd4, 8'h00); load_r8(3'd5, 8'h00);
        addr_sel = 2'd1; gp16_sel = 3'd4; r8_to_mem = 1; r8_src = 3'd7;
        tick(); idle();
        m_r8[4] = 8'hFF; m_r8[5] = 8'hFF;
        peek_hl("hlm_wrap");

        // HL+ selected but address source is PC: no post-update.
        addr_sel = 2'd0; gp16_sel = 3'd3; r8_to_mem = 1;
        tick(); idle();
        peek_hl("hl_no_step");

        // FF00+C read into Z, then A from the ALU.
        load_r8(3'd1, 8'h44);
        addr_sel = 2'd3; mem_to_z = 1; mem_rdata = 8'h9C;
        #1;
        put("ffc_addr", 16'hFF44); get(mem_addr);
        tick(); idle();
        peek_z("ffc_z", 8'h9C);
        capture_alu_res = 1; r8_dst = 3'd7; alu_res = 8'h9C;
        #1;
        put("a_no_bypass", {8'h00, m_r8[7]}); get({8'h00, alu_acc});
        tick(); idle(); m_r8[7] = 8'h9C;
        put("a_capture", 16'h009C); get({8'h00, alu_acc});

        // Z onto the bus overrides the register source.
        z_to_mem = 1; r8_to_mem = 1; r8_src = 3'd0;
        #1;
        put("z_wdata", 16'h009C); get({8'h00, mem_wdata});
        idle();

        // ALU result beats bus data; writes to slot 6 are discarded.
        capture_alu_res = 1; mem_to_r8 = 1; r8_dst = 3'd2;
        alu_res = 8'h11; mem_rdata = 8'h22;
        tick(); idle(); m_r8[2] = 8'h11;
        peek_r8("d_prio", 3'd2);
        capture_alu_res = 1; mem_to_r8 = 1; r8_dst = 3'd6;
        alu_res = 8'h77; mem_rdata = 8'h66;
        tick(); idle();
        for (int i = 0; i < 8; i++)
            if (i != 6) peek_r8($sformatf("hl_ind_r%0d", i), 3'(i));

        // r8 write to L during an HL+ access drops the step; flags load.
        load_r8(3'd4, 8'h12); load_r8(3'd5, 8'hFF);
        addr_sel = 2'd1; gp16_sel = 3'd3; mem_to_r8 = 1; r8_dst = 3'd5;
        mem_rdata = 8'hAA; update_flags = 1; alu_flags = 4'hF;
        tick(); idle();
        m_r8[5] = 8'hAA;
        peek_hl("hl_r8_wins");
        put("flags_f", 16'h000F); get({12'd0, flags});

        // Slot 6 means A on the bus and Z at the ALU.
        set_a(8'h3C);
        r8_to_mem = 1; r8_src = 3'd6; r8_to_alu_op1 = 1;
        #1;
        put("wdata_hl_a", 16'h003C); get({8'h00, mem_wdata});
        put("op1_hl_z", 16'h009C);   get({8'h00, alu_op1});
        idle();

        // Reset again with fetch controls active.
        rst = 1; inc_pc = 1; mem_to_ir = 1; mem_rdata = 8'hFF;
        tick(); rst = 0; idle();
`ifdef POST_BOOT_RESET_EN
        put("rst2_pc", 16'h0100); get(pc);
`else
        put("rst2_pc", 16'h0000); get(pc);
`endif
        put("rst2_ir", 16'h0000); get({8'h00, ir});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
